ball_motion_core: RTL and testbench
===================================

Name: ball_motion_core

Overview:
- Parametrised successor of the pingpong ball-motion datapath: one self-contained engine with serve, flight, wall reflection, paddle hit/miss, score and lives.
- Fixed-point position/velocity with configurable widths and playfield.
- Advances once per `tick` strobe, typically the VGA frame strobe.
- Drives `ball_x`/`ball_y` to the VGA renderer; takes paddle position and `swing` from the motion-sensor front end.

Parameters:
- COORD_W, 11: integer bits of each coordinate.
- FRAC_W, 4: fraction bits of position and velocity.
- VEL_W, 8: signed velocity width, including FRAC_W fraction bits.
- X_MAX, 639: right wall, integer pixels.
- Y_MAX, 479: bottom limit, integer pixels.
- PAD_HALF, 32: paddle half-width, pixels.
- VMAG_MAX, 120: maximum velocity magnitude, raw units.
- SERVE_TICKS, 24: ticks to wait before launch.
- LIVES, 3: misses allowed per game.
- SCORE_W, 4: score width.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- tick, in, 1: one-cycle update strobe.
- start, in, 1: begin game; sampled only in IDLE.
- serve_x, in, COORD_W: launch x.
- serve_y, in, COORD_W: launch y.
- serve_vx, in, VEL_W: signed launch x-velocity.
- serve_vy, in, VEL_W: signed launch y-velocity.
- pad_x, in, COORD_W: paddle centre x.
- pad_y, in, COORD_W: paddle surface y.
- swing, in, 1: swing active.
- ball_x, out, COORD_W: integer part of x position.
- ball_y, out, COORD_W: integer part of y position.
- hit, out, 1: one-cycle pulse on paddle hit.
- miss, out, 1: one-cycle pulse on miss.
- score, out, SCORE_W: hit count.
- lives_left, out, 2: remaining lives.
- in_play, out, 1: high in MOVE.
- game_over, out, 1: high after the last life is lost, until next start.

Behaviour:
- Reset values: state=IDLE, all outputs 0, lives_left=LIVES, velocities 0. Reset wins over every other event; reset mid-flight returns to IDLE in one cycle.
- Position registers: COORD_W+FRAC_W bits, unsigned. Velocities: VEL_W bits, two's complement, sign-extended before add. Next-position is computed one bit wider so underflow and overflow are visible.
- IDLE:
  - On start: latch the serve_* inputs into serve registers, load position and velocity from them, score=0, lives_left=LIVES, game_over=0.
  - Then go to SERVE with the serve counter at 0.
- SERVE:
  - Each tick increments the counter.
  - When the counter reaches SERVE_TICKS-1 on a tick, go to MOVE.
  - Position is held during SERVE.
- MOVE, on each tick, with all results registered (outputs change the cycle after tick):
  - X axis: nx=x+vx. If nx<0, then x=0 and vx=-vx. If nx>X_MAX<<FRAC_W, then x=X_MAX<<FRAC_W and vx=-vx. Otherwise x=nx.
  - Y top: if ny<0, then y=0 and vy=-vy.
  - Y paddle: applies when vy>0, y_int<pad_y, ny_int>=pad_y, |nx_int-pad_x|<=PAD_HALF and swing=1.
    - y=pad_y<<FRAC_W, vy=-(|vy|+1), with the magnitude saturating at VMAG_MAX.
    - score increments, saturating at all-ones.
    - hit pulses.
  - Y out: if ny_int>Y_MAX, miss pulses and the state goes to OUT. Paddle-hit priority is above out.
  - Corner case: if x and y both reflect in one tick, both are applied.
- OUT, one cycle:
  - lives_left decrements.
  - If the result is 0: game_over=1, go to IDLE.
  - Otherwise reload position and velocity from the serve registers and go to SERVE.
- Non-tick cycles change no state except the OUT transition.
- start outside IDLE is ignored. tick in IDLE or OUT is ignored.
- hit and miss are never both high in the same cycle.

Optional Feature:
- Macro SPIN_EN.
- Defined: on a hit, vx += (nx_int-pad_x)>>2, clamped to ±VMAG_MAX.
- Undefined: vx is unchanged on a hit; no offset logic is synthesised.

Decomposition:
- Package motion_pkg holds:
  - the state enum {IDLE, SERVE, MOVE, OUT};
  - the fixed-point width constants;
  - saturating negate and saturating-magnitude functions.
- Sub-module ball_axis_step does one axis of add, clamp and reflect: inputs pos, vel, max; outputs new pos, new vel, lo_hit, hi_hit. It is instantiated for x and for y (y max = Y_MAX, hi_hit used as out/paddle candidate).

Test Plan:
- Serve and straight flight: start with serve (100,100), vx=16, vy=0, SERVE_TICKS=24. Expect no motion for 24 ticks, then ball_x=101,102,… one per tick, ball_y=100.
- Left wall: x=1, vx=-32. Expect ball_x=0 after the next tick, vx=+32, then ball_x=2.
- Paddle hit: y=438, vy=+48, pad_y=440, pad_x=ball_x+10, swing=1. Expect ball_y=440, hit pulse for 1 cycle, score=1, vy=-49.
- Miss and game over: swing=0, ball falls past Y_MAX=479 three times. Expect miss pulses, lives_left 2→1→0, reserve after the first two misses, game_over=1 and IDLE after the third.
- Reset mid-flight: assert rst while in MOVE with score=5. Expect all outputs 0, lives_left=3, next start works normally.
- SPIN_EN: hit with offset +20. Expect vx to increase by 5; verify the same stimulus leaves vx unchanged without the macro.

Source files
------------

// File: rtl/motion_pkg.sv
// Shared types and helpers for the ball-motion engine: the game-state
// enum, the default fixed-point widths, and velocity saturation functions.
package motion_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    MOVE  = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Default fixed-point geometry: 11 integer bits, 4 fraction bits, and
  // an 8-bit signed velocity.
  localparam int COORD_W_DEF = 11;
  localparam int FRAC_W_DEF  = 4;
  localparam int VEL_W_DEF   = 8;

  // Magnitude of v, limited to vmax.
  function automatic int sat_mag(input int v, input int vmax);
    int m;
    m = (v < 0) ? -v : v;
    return (m > vmax) ? vmax : m;
  endfunction

  // Clamp v into the range [-vmax, +vmax].
  function automatic int sat_clamp(input int v, input int vmax);
    int m;
    m = sat_mag(v, vmax);
    return (v < 0) ? -m : m;
  endfunction

  // Negate v and clamp the result into [-vmax, +vmax]. This also avoids
  // the two's-complement overflow when negating the most negative value.
  function automatic int sat_neg(input int v, input int vmax);
    return sat_clamp(-v, vmax);
  endfunction

endpackage

// File: rtl/ball_axis_step.sv
// One axis of ball motion: adds velocity to position one bit wider, then
// clamps at 0 / max and reflects velocity on either wall. The raw sum is
// exported so callers can run their own crossing tests.
module ball_axis_step
  import motion_pkg::*;
#(
  parameter int POS_W    = 15,
  parameter int VEL_W    = 8,
  parameter int VMAG_MAX = 120
) (
  input  logic [POS_W-1:0]        pos,
  input  logic signed [VEL_W-1:0] vel,
  input  logic [POS_W-1:0]        max,
  output logic signed [POS_W:0]   sum,
  output logic [POS_W-1:0]        new_pos,
  output logic signed [VEL_W-1:0] new_vel,
  output logic                    lo_hit,
  output logic                    hi_hit
);

  logic signed [POS_W:0]   vel_ext;
  logic signed [VEL_W-1:0] vel_neg;

  assign vel_ext = {{(POS_W + 1 - VEL_W){vel[VEL_W-1]}}, vel};
  assign sum     = $signed({1'b0, pos}) + vel_ext;
  assign vel_neg = VEL_W'(sat_neg(int'(vel), VMAG_MAX));
  assign lo_hit  = sum[POS_W];
  assign hi_hit  = !sum[POS_W] && (sum[POS_W-1:0] > max);

  // Clamp and reflect against the low and high limits.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a latch.
    new_pos = sum[POS_W-1:0];
    new_vel = vel;
    if (lo_hit) begin
      new_pos = '0;
      new_vel = vel_neg;
    end else if (hi_hit) begin
      new_pos = max;
      new_vel = vel_neg;
    end
  end

endmodule

// File: rtl/ball_motion_core.sv
// Ball-motion engine: serve, flight, wall reflection, paddle hit/miss,
// score and lives. All state advances once per tick strobe.
// Optional macro SPIN_EN: when defined, a paddle hit adds a quarter of
// the ball's offset from the paddle centre to vx.
module ball_motion_core
  import motion_pkg::*;
#(
  parameter int COORD_W     = COORD_W_DEF,
  parameter int FRAC_W      = FRAC_W_DEF,
  parameter int VEL_W       = VEL_W_DEF,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int PAD_HALF    = 32,
  parameter int VMAG_MAX    = 120,
  parameter int SERVE_TICKS = 24,
  parameter int LIVES       = 3,
  parameter int SCORE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               start,
  input  logic [COORD_W-1:0] serve_x,
  input  logic [COORD_W-1:0] serve_y,
  input  logic [VEL_W-1:0]   serve_vx,
  input  logic [VEL_W-1:0]   serve_vy,
  input  logic [COORD_W-1:0] pad_x,
  input  logic [COORD_W-1:0] pad_y,
  input  logic               swing,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives_left,
  output logic               in_play,
  output logic               game_over
);

  localparam int POS_W = COORD_W + FRAC_W;
  localparam int CNT_W = $clog2(SERVE_TICKS + 1);
  // The x wall sits exactly on X_MAX. The y limit includes the whole
  // Y_MAX pixel, so the ball is out only once its integer part passes Y_MAX.
  localparam logic [POS_W-1:0] X_LIM = POS_W'(X_MAX * (2 ** FRAC_W));
  localparam logic [POS_W-1:0] Y_LIM = POS_W'((Y_MAX + 1) * (2 ** FRAC_W) - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [POS_W-1:0]        pos_x, pos_y;
  logic signed [VEL_W-1:0] vel_x, vel_y;
  logic [COORD_W-1:0]      srv_x, srv_y;
  logic [VEL_W-1:0]        srv_vx, srv_vy;

  logic signed [POS_W:0]   sum_x, sum_y;
  logic [POS_W-1:0]        nx_pos, ny_pos;
  logic signed [VEL_W-1:0] nx_vel, ny_vel;
  logic                    x_lo, x_hi, y_lo, y_hi;

  int                      nx_int, ny_int, y_int, dx;
  logic                    paddle;
  logic signed [VEL_W-1:0] paddle_vy, hit_vx;
  logic                    unused;

  ball_axis_step #(.POS_W(POS_W), .VEL_W(VEL_W), .VMAG_MAX(VMAG_MAX)) u_step_x (
    .pos(pos_x), .vel(vel_x), .max(X_LIM), .sum(sum_x),
    .new_pos(nx_pos), .new_vel(nx_vel), .lo_hit(x_lo), .hi_hit(x_hi)
  );

  ball_axis_step #(.POS_W(POS_W), .VEL_W(VEL_W), .VMAG_MAX(VMAG_MAX)) u_step_y (
    .pos(pos_y), .vel(vel_y), .max(Y_LIM), .sum(sum_y),
    .new_pos(ny_pos), .new_vel(ny_vel), .lo_hit(y_lo), .hi_hit(y_hi)
  );

  // The x axis reflects on its own. Its wall flags and fraction bits are
  // only observed through nx_pos and nx_vel.
  assign unused = &{1'b0, x_lo, x_hi, y_lo, sum_x[FRAC_W-1:0], sum_y[FRAC_W-1:0]};

  // Paddle-crossing test, and the velocities applied on a hit.
  always_comb begin
    nx_int    = int'(sum_x >>> FRAC_W);
    ny_int    = int'(sum_y >>> FRAC_W);
    y_int     = int'(pos_y[POS_W-1:FRAC_W]);
    dx        = nx_int - int'(pad_x);
    paddle    = swing && (vel_y > 0) && (y_int < int'(pad_y)) &&
                (ny_int >= int'(pad_y)) && (dx <= PAD_HALF) && (dx >= -PAD_HALF);
    paddle_vy = VEL_W'(sat_neg(int'(vel_y) + 1, VMAG_MAX));
`ifdef SPIN_EN
    hit_vx    = VEL_W'(sat_clamp(int'(nx_vel) + (dx >>> 2), VMAG_MAX));
`else
    hit_vx    = nx_vel;
`endif
  end

  // Game FSM with registered position, velocity, score and pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses <= only, so every reader sees the
      // pre-edge value regardless of statement order.
      state      <= IDLE;
      cnt        <= '0;
      pos_x      <= '0;
      pos_y      <= '0;
      vel_x      <= '0;
      vel_y      <= '0;
      srv_x      <= '0;
      srv_y      <= '0;
      srv_vx     <= '0;
      srv_vy     <= '0;
      score      <= '0;
      lives_left <= 2'(LIVES);
      game_over  <= 1'b0;
      hit        <= 1'b0;
      miss       <= 1'b0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            srv_x      <= serve_x;
            srv_y      <= serve_y;
            srv_vx     <= serve_vx;
            srv_vy     <= serve_vy;
            pos_x      <= {serve_x, FRAC_W'(0)};
            pos_y      <= {serve_y, FRAC_W'(0)};
            vel_x      <= serve_vx;
            vel_y      <= serve_vy;
            score      <= '0;
            lives_left <= 2'(LIVES);
            game_over  <= 1'b0;
            cnt        <= '0;
            state      <= SERVE;
          end
        end
        SERVE: begin
          if (tick) begin
            if (cnt == CNT_W'(SERVE_TICKS - 1)) state <= MOVE;
            else                                cnt   <= cnt + 1'b1;
          end
        end
        MOVE: begin
          if (tick) begin
            pos_x <= nx_pos;
            vel_x <= nx_vel;
            if (paddle) begin
              pos_y <= {pad_y, FRAC_W'(0)};
              vel_y <= paddle_vy;
              vel_x <= hit_vx;
              score <= (score == '1) ? score : score + 1'b1;
              hit   <= 1'b1;
            end else if (y_hi) begin
              miss  <= 1'b1;
              state <= OUT;
            end else begin
              pos_y <= ny_pos;
              vel_y <= ny_vel;
            end
          end
        end
        OUT: begin
          lives_left <= lives_left - 1'b1;
          if (lives_left == 2'd1) begin
            game_over <= 1'b1;
            state     <= IDLE;
          end else begin
            pos_x <= {srv_x, FRAC_W'(0)};
            pos_y <= {srv_y, FRAC_W'(0)};
            vel_x <= srv_vx;
            vel_y <= srv_vy;
            cnt   <= '0;
            state <= SERVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ball_x  = pos_x[POS_W-1:FRAC_W];
  assign ball_y  = pos_y[POS_W-1:FRAC_W];
  assign in_play = (state == MOVE);

endmodule

// File: tb/tb_ball_motion_core.sv
// Directed self-checking bench for ball_motion_core with default parameters.
// Compile with +define+SPIN_EN to select the spin expectations.
`timescale 1ns/1ps
module tb_ball_motion_core;

  logic        clk = 1'b0;
  logic        rst, tick, start, swing;
  logic [10:0] serve_x, serve_y, pad_x, pad_y;
  logic [7:0]  serve_vx, serve_vy;
  logic [10:0] ball_x, ball_y;
  logic        hit, miss, in_play, game_over;
  logic [3:0]  score;
  logic [1:0]  lives_left;

  int n_checks = 0;
  int n_errors = 0;

  ball_motion_core dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .serve_x(serve_x), .serve_y(serve_y), .serve_vx(serve_vx), .serve_vy(serve_vy),
    .pad_x(pad_x), .pad_y(pad_y), .swing(swing),
    .ball_x(ball_x), .ball_y(ball_y), .hit(hit), .miss(miss),
    .score(score), .lives_left(lives_left), .in_play(in_play), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after a rising edge; outputs are sampled there too.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic start_game(input logic [10:0] x, input logic [10:0] y,
                            input logic [7:0] vx, input logic [7:0] vy);
    serve_x  = x;
    serve_y  = y;
    serve_vx = vx;
    serve_vy = vy;
    start    = 1'b1;
    cycle();
    start    = 1'b0;
  endtask

  task automatic serve_wait();
    repeat (24) do_tick();
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; swing = 1'b0;
    serve_x = '0; serve_y = '0; serve_vx = '0; serve_vy = '0;
    pad_x = 11'd0; pad_y = 11'd470;
    cycle();
    cycle();
    rst = 1'b0;

    // Reset state
    check("rst_ball_x", ball_x, 0);
    check("rst_ball_y", ball_y, 0);
    check("rst_score", score, 0);
    check("rst_lives", lives_left, 3);
    check("rst_flags", {hit, miss, in_play, game_over}, 4'b0000);

    // Serve and straight flight: 24 held ticks, then +1 pixel per tick
    start_game(11'd100, 11'd100, 8'd16, 8'd0);
    check("srv_x", ball_x, 100);
    check("srv_y", ball_y, 100);
    repeat (23) do_tick();
    check("srv_hold_x", ball_x, 100);
    check("srv_not_play", in_play, 0);
    do_tick();
    check("srv_launch_play", in_play, 1);
    check("srv_launch_x", ball_x, 100);
    do_tick();
    check("fly_x1", ball_x, 101);
    do_tick();
    check("fly_x2", ball_x, 102);
    check("fly_y", ball_y, 100);
    repeat (3) cycle();
    check("no_tick_hold", ball_x, 102);
    start_game(11'd5, 11'd5, 8'd0, 8'd0);
    check("start_ignored_x", ball_x, 102);
    do_tick();
    check("start_ignored_fly", ball_x, 103);

    // Left wall: x=1, vx=-32 (8'hE0)
    do_reset();
    start_game(11'd1, 11'd100, 8'hE0, 8'd0);
    serve_wait();
    do_tick();
    check("lwall_clamp", ball_x, 0);
    do_tick();
    check("lwall_reflect", ball_x, 2);

    // Right wall: x=638, vx=+32 overshoots X_MAX
    do_reset();
    start_game(11'd638, 11'd100, 8'd32, 8'd0);
    serve_wait();
    do_tick();
    check("rwall_clamp", ball_x, 639);
    do_tick();
    check("rwall_reflect", ball_x, 637);

    // Paddle hit: y=438, vy=+48, pad_y=440, pad_x=ball_x+10
    do_reset();
    pad_y = 11'd440; pad_x = 11'd310; swing = 1'b1;
    start_game(11'd300, 11'd438, 8'd0, 8'd48);
    serve_wait();
    do_tick();
    check("pad_hit", hit, 1);
    check("pad_y", ball_y, 440);
    check("pad_score", score, 1);
    check("pad_nomiss", miss, 0);
    cycle();
    check("pad_hit_pulse", hit, 0);
    do_tick();
    check("pad_vy49_a", ball_y, 436);
    do_tick();
    check("pad_vy49_b", ball_y, 433);

    // Spin: hit with offset +20 from paddle centre
    do_reset();
    pad_y = 11'd440; pad_x = 11'd280; swing = 1'b1;
    start_game(11'd300, 11'd438, 8'd0, 8'd48);
    serve_wait();
    do_tick();
    check("spin_hit", hit, 1);
    repeat (3) do_tick();
    check("spin_x3", ball_x, 300);
    do_tick();
`ifdef SPIN_EN
    check("spin_x4", ball_x, 301);
`else
    check("spin_x4", ball_x, 300);
`endif

    // Miss and game over: y=470, vy=+48, no swing
    do_reset();
    swing = 1'b0;
    start_game(11'd300, 11'd470, 8'd0, 8'd48);
    for (int m = 0; m < 3; m++) begin
      serve_wait();
      repeat (3) do_tick();
      check("miss_edge_y", ball_y, 479);
      check("miss_edge_nomiss", miss, 0);
      do_tick();
      check("miss_pulse", miss, 1);
      check("miss_nohit", hit, 0);
      cycle();
      check("miss_pulse_end", miss, 0);
      check("miss_lives", lives_left, 32'(2 - m));
      check("miss_not_play", in_play, 0);
      if (m < 2) begin
        check("miss_reserve_y", ball_y, 470);
        check("miss_not_over", game_over, 0);
      end else begin
        check("miss_game_over", game_over, 1);
      end
    end
    repeat (30) do_tick();
    check("over_idle_play", in_play, 0);
    check("over_sticky", game_over, 1);
    start_game(11'd50, 11'd60, 8'd0, 8'd0);
    check("restart_over_clr", game_over, 0);
    check("restart_lives", lives_left, 3);
    check("restart_x", ball_x, 50);

    // Reset mid-flight with score 5: bounce between top wall and a paddle at y=20
    do_reset();
    pad_y = 11'd20; pad_x = 11'd300; swing = 1'b1;
    start_game(11'd300, 11'd10, 8'd0, 8'd48);
    serve_wait();
    for (int b = 0; b < 400 && score != 4'd5; b++) do_tick();
    check("score_reach5", score, 5);
    check("score5_in_play", in_play, 1);
    do_reset();
    check("midrst_ball_x", ball_x, 0);
    check("midrst_ball_y", ball_y, 0);
    check("midrst_score", score, 0);
    check("midrst_lives", lives_left, 3);
    check("midrst_flags", {hit, miss, in_play, game_over}, 4'b0000);
    swing = 1'b0;
    start_game(11'd100, 11'd100, 8'd16, 8'd0);
    serve_wait();
    do_tick();
    check("midrst_restart_x", ball_x, 101);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
